// File: rtl/csr_commit_if.sv
// csr_commit_if: X-stage CSR request, retire strobe and MW-facing response bundle.
// Ports (via modports):
//    master  drives the requests (stall, x_csr_*, x_kill, wb_retire) and observes the response
//    slave   the CSR unit: samples the requests and drives wb_csr_rdata/rvalid, tohost, tohost_wr, csr_illegal
interface csr_commit_if #(parameter int XLEN = 32);
   logic            stall;
   logic            x_csr_valid;
   logic [1:0]      x_csr_op;
   logic [11:0]     x_csr_addr;
   logic [XLEN-1:0] x_csr_wdata;
   logic            x_csr_rd_nz;
   logic            x_kill;
   logic            wb_retire;
   logic [XLEN-1:0] wb_csr_rdata;
   logic            wb_csr_rvalid;
   logic [XLEN-1:0] tohost;
   logic            tohost_wr;
   logic            csr_illegal;
   modport master (
      output stall, x_csr_valid, x_csr_op, x_csr_addr, x_csr_wdata, x_csr_rd_nz, x_kill, wb_retire,
      input  wb_csr_rdata, wb_csr_rvalid, tohost, tohost_wr, csr_illegal
   );
   modport slave (
      input  stall, x_csr_valid, x_csr_op, x_csr_addr, x_csr_wdata, x_csr_rd_nz, x_kill, wb_retire,
      output wb_csr_rdata, wb_csr_rvalid, tohost, tohost_wr, csr_illegal
   );
endinterface

// File: rtl/csr_commit_unit.sv
// csr_commit_unit: CSR responder that commits on the X->MW edge and returns the old value to MW.
// Ports:
//    clk    rising-edge clock
//    reset  synchronous, active-high
//    bus    csr_commit_if.slave: X-stage request, retire strobe, stall, and the MW-facing
//           read data/valid, tohost register, tohost_wr and csr_illegal pulses
// CYCLE_RST/INSTRET_RST are the counter values loaded by reset (0 in normal use).
module csr_commit_unit #(
   parameter int          XLEN          = 32,
   parameter logic [11:0] ADDR_TOHOST   = 12'h51E,
   parameter logic [11:0] ADDR_CYCLE    = 12'hC00,
   parameter logic [11:0] ADDR_CYCLEH   = 12'hC80,
   parameter logic [11:0] ADDR_INSTRET  = 12'hC02,
   parameter logic [11:0] ADDR_INSTRETH = 12'hC82,
   parameter logic [63:0] CYCLE_RST     = 64'd0,
   parameter logic [63:0] INSTRET_RST   = 64'd0
) (
   input logic         clk,
   input logic         reset,
   csr_commit_if.slave bus
);
   logic [63:0]     cycle, instret;
   logic [XLEN-1:0] tohost_q, rdata_q, old, nv;
   logic            rvalid_q, tohost_wr_q, illegal_q;
   logic            acc, is_tohost, is_cnt, wr, illegal, commit;
   always_comb begin
      acc       = bus.x_csr_valid & ~bus.x_kill & ~bus.stall;
      is_tohost = bus.x_csr_addr == ADDR_TOHOST;
      is_cnt    = bus.x_csr_addr == ADDR_CYCLE   | bus.x_csr_addr == ADDR_CYCLEH |
                  bus.x_csr_addr == ADDR_INSTRET | bus.x_csr_addr == ADDR_INSTRETH;
      old       = is_tohost                        ? tohost_q :
                  bus.x_csr_addr == ADDR_CYCLE     ? cycle[31:0] :
                  bus.x_csr_addr == ADDR_CYCLEH    ? cycle[63:32] :
                  bus.x_csr_addr == ADDR_INSTRET   ? instret[31:0] :
                  bus.x_csr_addr == ADDR_INSTRETH  ? instret[63:32] : '0;
      // set/clear with a zero mask is a pure read and may target read-only counters
      wr        = bus.x_csr_op == 2'b01 | (bus.x_csr_op[1] & |bus.x_csr_wdata);
      illegal   = bus.x_csr_op == 2'b00 | ~(is_tohost | is_cnt) | (is_cnt & wr);
      nv        = bus.x_csr_op == 2'b01 ? bus.x_csr_wdata :
                  bus.x_csr_op == 2'b10 ? old | bus.x_csr_wdata : old & ~bus.x_csr_wdata;
      commit    = acc & ~illegal;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         cycle       <= CYCLE_RST;
         instret     <= INSTRET_RST;
         tohost_q    <= '0;
         rdata_q     <= '0;
         rvalid_q    <= 1'b0;
         tohost_wr_q <= 1'b0;
         illegal_q   <= 1'b0;
      end else begin
         cycle       <= cycle + 64'd1;
         if (bus.wb_retire & ~bus.stall) instret <= instret + 64'd1;
         if (commit & is_tohost & wr) tohost_q <= nv;
         tohost_wr_q <= commit & is_tohost & wr;
         illegal_q   <= acc & illegal;
         if (commit) rdata_q <= old;
         if (~bus.stall) rvalid_q <= commit & bus.x_csr_rd_nz;
      end
   end
   assign bus.tohost        = tohost_q;
   assign bus.tohost_wr     = tohost_wr_q;
   assign bus.csr_illegal   = illegal_q;
   assign bus.wb_csr_rdata  = rdata_q;
   assign bus.wb_csr_rvalid = rvalid_q;
endmodule

// File: tb/tb_csr_commit_unit.sv
// tb_csr_commit_unit: directed and randomized checks of csr_commit_unit against a behavioural model.
module tb_csr_commit_unit;
   localparam logic [63:0] CINIT = 64'hFFFF_FFF0;
   localparam logic [63:0] IINIT = 64'h0000_0000_FFFF_FFFF;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;
   csr_commit_if #(.XLEN(32)) bus();
   csr_commit_unit #(.CYCLE_RST(CINIT), .INSTRET_RST(IINIT)) dut (.clk(clk), .reset(reset), .bus(bus));
   int total = 0, bad = 0;
   logic [31:0] m_tohost, m_rdata;
   logic        m_rvalid, m_wr, m_ill;
   logic [63:0] m_cycle, m_instret;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   // returns {mapped, read-only, value}
   function automatic logic [33:0] m_lookup(input logic [11:0] a);
      case (a)
         12'h51E: return {1'b1, 1'b0, m_tohost};
         12'hC00: return {1'b1, 1'b1, m_cycle[31:0]};
         12'hC80: return {1'b1, 1'b1, m_cycle[63:32]};
         12'hC02: return {1'b1, 1'b1, m_instret[31:0]};
         12'hC82: return {1'b1, 1'b1, m_instret[63:32]};
         default: return 34'd0;
      endcase
   endfunction
   task automatic model_edge();
      logic [33:0] l;
      logic writes;
      logic [31:0] w;
      if (reset) begin
         m_tohost = 0; m_rdata = 0; m_rvalid = 0; m_wr = 0; m_ill = 0;
         m_cycle = CINIT; m_instret = IINIT;
         return;
      end
      m_wr = 0; m_ill = 0;
      w = bus.x_csr_wdata;
      if (bus.x_csr_valid && !bus.x_kill && !bus.stall) begin
         l = m_lookup(bus.x_csr_addr);
         writes = (bus.x_csr_op == 2'b01) || (bus.x_csr_op != 2'b00 && w != 0);
         if (bus.x_csr_op == 2'b00 || !l[33] || (l[32] && writes)) begin
            m_ill = 1; m_rvalid = 0;
         end else begin
            m_rdata = l[31:0];
            m_rvalid = bus.x_csr_rd_nz;
            if (writes && bus.x_csr_addr == 12'h51E) begin
               m_wr = 1;
               if (bus.x_csr_op == 2'b01) m_tohost = w;
               else if (bus.x_csr_op == 2'b10) m_tohost = m_tohost | w;
               else m_tohost = m_tohost & ~w;
            end
         end
      end else if (!bus.stall) m_rvalid = 0;
      m_cycle++;
      if (bus.wb_retire && !bus.stall) m_instret++;
   endtask
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("tohost", bus.tohost, m_tohost);
      check("tohost_wr", bus.tohost_wr, m_wr);
      check("illegal", bus.csr_illegal, m_ill);
      check("rvalid", bus.wb_csr_rvalid, m_rvalid);
      check("rdata", bus.wb_csr_rdata, m_rdata);
   endtask
   task automatic drive(input logic v, input logic [1:0] op, input logic [11:0] a, input logic [31:0] d,
                        input logic rdnz, input logic kill, input logic st, input logic ret);
      bus.x_csr_valid = v; bus.x_csr_op = op; bus.x_csr_addr = a; bus.x_csr_wdata = d;
      bus.x_csr_rd_nz = rdnz; bus.x_kill = kill; bus.stall = st; bus.wb_retire = ret;
   endtask
   task automatic idle();
      drive(0, 2'b00, 12'h000, 0, 0, 0, 0, 0);
   endtask
   initial begin
      logic [11:0] addrs [6];
      addrs = '{12'h51E, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'h300};
      reset = 1; idle();
      step();
      check("rst_tohost", bus.tohost, 0);
      check("rst_rvalid", bus.wb_csr_rvalid, 0);
      reset = 0;
      drive(1, 2'b01, 12'h51E, 32'h1, 0, 0, 0, 0); step();
      check("csrw_tohost", bus.tohost, 1);
      check("csrw_wr", bus.tohost_wr, 1);
      idle(); step();
      check("wr_pulse_clr", bus.tohost_wr, 0);
      drive(1, 2'b01, 12'h51E, 32'hAB, 0, 1, 0, 0); step();
      check("kill_tohost", bus.tohost, 1);
      check("kill_wr", bus.tohost_wr, 0);
      drive(1, 2'b01, 12'h51E, 32'hF0, 0, 0, 0, 0); step();
      drive(1, 2'b11, 12'h51E, 32'h30, 1, 0, 0, 0); step();
      check("rc_rdata", bus.wb_csr_rdata, 32'hF0);
      check("rc_rvalid", bus.wb_csr_rvalid, 1);
      check("rc_tohost", bus.tohost, 32'hC0);
      drive(1, 2'b01, 12'hC00, 32'h5, 1, 0, 0, 0); step();
      check("ro_illegal", bus.csr_illegal, 1);
      check("ro_rvalid", bus.wb_csr_rvalid, 0);
      drive(1, 2'b10, 12'hC00, 32'h0, 1, 0, 0, 0); step();
      check("cyc_rd_legal", bus.csr_illegal, 0);
      check("cyc_rd_rvalid", bus.wb_csr_rvalid, 1);
      reset = 1; idle(); step(); reset = 0;
      drive(0, 2'b00, 12'h000, 0, 0, 0, 0, 1); step();
      drive(1, 2'b10, 12'hC82, 32'h0, 1, 0, 0, 0); step();
      check("instreth_carry", bus.wb_csr_rdata, 1);
      drive(0, 2'b00, 12'h000, 0, 0, 0, 1, 1); step();
      drive(1, 2'b10, 12'hC02, 32'h0, 1, 0, 0, 0); step();
      check("instret_lo_stall", bus.wb_csr_rdata, 0);
      drive(1, 2'b01, 12'h51E, 32'h55, 1, 0, 0, 1); reset = 1; step();
      check("rst_mid_tohost", bus.tohost, 0);
      check("rst_mid_rdata", bus.wb_csr_rdata, 0);
      check("rst_mid_wr", bus.tohost_wr, 0);
      reset = 0;
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(1, 0) == 1, 2'($urandom), addrs[$urandom_range(5, 0)],
               $urandom_range(3, 0) == 0 ? 32'd0 : $urandom, 1'($urandom),
               $urandom_range(6, 0) == 0, $urandom_range(4, 0) == 0, 1'($urandom));
         reset = $urandom_range(99, 0) == 0;
         step();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
